// File: rtl/compact_bf_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : compact_bf_pipe (with helpers compact_bf_modmul, compact_bf_stage)
//  Description : Pipelined 4-input butterfly unit for a mixed-radix NTT
//                datapath. Runs either two independent radix-2 butterflies
//                (DUAL) or one fused two-stage radix-2^2 butterfly (FUSED),
//                forward (Cooley-Tukey) or inverse (Gentleman-Sande).
//                Fixed latency 2*(MUL_LAT+1) enabled cycles for every mode;
//                the whole pipe stalls when the output is held.
//  Ports       : clk, rst (async, active-high)
//                in_valid/in_ready, fused, inv, x0..x3, w1..w3  (input beat)
//                out_valid/out_ready, y0..y3                    (output beat)
//  Options     : BF_INTT_HALVE_EN - when defined, every GS butterfly output
//                is halved mod Q (FUSED INTT outputs end up scaled by 1/4).
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Exact a*b mod Q, MUL_LAT register stages. The raw product travels through
// the first MUL_LAT-1 registers and is reduced before the last one.
// ----------------------------------------------------------------------------
module compact_bf_modmul #(
  parameter int DW      = 12,
  parameter int Q       = 3329,
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_p
);
  localparam logic [2*DW-1:0] c_q = (2*DW)'(Q);

  logic [2*DW-1:0] w_prod;
  logic [DW-1:0]   r_p;

  assign w_prod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};

  generate
    if (MUL_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_p <= '0;
        end else if (i_en) begin
          r_p <= DW'(w_prod % c_q);
        end
      end
    end else begin : g_latn
      logic [2*DW-1:0] r_raw [MUL_LAT-1];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < MUL_LAT-1; k++) r_raw[k] <= '0;
          r_p <= '0;
        end else if (i_en) begin
          r_raw[0] <= w_prod;
          for (int k = 1; k < MUL_LAT-1; k++) r_raw[k] <= r_raw[k-1];
          r_p <= DW'(r_raw[MUL_LAT-2] % c_q);
        end
      end
    end
  endgenerate

  assign o_p = r_p;
endmodule

// ----------------------------------------------------------------------------
// One butterfly stage: two radix-2 butterflies, MUL_LAT+1 cycles deep.
// Lane pairing is adjacent (0,1)/(2,3) or strided (0,2)/(1,3). In bypass the
// lanes are only delayed. Raw u/v ride alongside the multiplier so that CT
// sums, GS sums and bypass are all formed after the multiply.
// ----------------------------------------------------------------------------
module compact_bf_stage #(
  parameter int DW      = 12,
  parameter int Q       = 3329,
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_valid,
  input  logic          i_inv,
  input  logic          i_strided,
  input  logic          i_bypass,
  input  logic [DW-1:0] i_l0,
  input  logic [DW-1:0] i_l1,
  input  logic [DW-1:0] i_l2,
  input  logic [DW-1:0] i_l3,
  input  logic [DW-1:0] i_wa,
  input  logic [DW-1:0] i_wb,
  output logic          o_valid,
  output logic [DW-1:0] o_l0,
  output logic [DW-1:0] o_l1,
  output logic [DW-1:0] o_l2,
  output logic [DW-1:0] o_l3
);
  localparam logic [DW:0] c_q    = (DW+1)'(Q);
  localparam int          c_last = MUL_LAT - 1;

  function automatic logic [DW-1:0] f_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= c_q) s = s - c_q;
    return s[DW-1:0];
  endfunction

  // a + Q - b lies in [1, 2Q-1] for reduced inputs; one conditional subtract.
  function automatic logic [DW-1:0] f_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + c_q - {1'b0, b};
    if (s >= c_q) s = s - c_q;
    return s[DW-1:0];
  endfunction

  // a/2 mod Q: odd values become even by adding the (odd) modulus first.
  function automatic logic [DW-1:0] f_half(input logic [DW-1:0] a);
    logic [DW:0] s;
    s = {1'b0, a};
    if (a[0]) s = s + c_q;
    return s[DW:1];
  endfunction

  function automatic logic [DW-1:0] f_gs_scale(input logic [DW-1:0] a);
`ifdef BF_INTT_HALVE_EN
    return f_half(a);
`else
    return a;
`endif
  endfunction

  logic [DW-1:0] w_u0, w_v0, w_u1, w_v1, w_ma0, w_ma1, w_m0, w_m1;
  logic [DW-1:0] w_e0, w_f0, w_e1, w_f1;
  logic [DW-1:0] w_y0, w_y1, w_y2, w_y3;

  logic          r_vld [MUL_LAT];
  logic          r_inv [MUL_LAT];
  logic          r_str [MUL_LAT];
  logic          r_byp [MUL_LAT];
  logic [DW-1:0] r_u0  [MUL_LAT];
  logic [DW-1:0] r_v0  [MUL_LAT];
  logic [DW-1:0] r_u1  [MUL_LAT];
  logic [DW-1:0] r_v1  [MUL_LAT];

  logic          r_out_valid;
  logic [DW-1:0] r_o0, r_o1, r_o2, r_o3;

  assign w_u0 = i_l0;
  assign w_v0 = i_strided ? i_l2 : i_l1;
  assign w_u1 = i_strided ? i_l1 : i_l2;
  assign w_v1 = i_l3;

  // CT multiplies v by w; GS multiplies (u - v) by w.
  assign w_ma0 = i_inv ? f_sub(w_u0, w_v0) : w_v0;
  assign w_ma1 = i_inv ? f_sub(w_u1, w_v1) : w_v1;

  compact_bf_modmul #(.DW(DW), .Q(Q), .MUL_LAT(MUL_LAT)) u_mul0 (
    .clk (clk), .rst (rst), .i_en (i_en), .i_a (w_ma0), .i_b (i_wa), .o_p (w_m0)
  );
  compact_bf_modmul #(.DW(DW), .Q(Q), .MUL_LAT(MUL_LAT)) u_mul1 (
    .clk (clk), .rst (rst), .i_en (i_en), .i_a (w_ma1), .i_b (i_wb), .o_p (w_m1)
  );

  always_comb begin
    if (r_byp[c_last]) begin
      w_e0 = r_u0[c_last];
      w_f0 = r_v0[c_last];
      w_e1 = r_u1[c_last];
      w_f1 = r_v1[c_last];
    end else if (r_inv[c_last]) begin
      w_e0 = f_gs_scale(f_add(r_u0[c_last], r_v0[c_last]));
      w_f0 = f_gs_scale(w_m0);
      w_e1 = f_gs_scale(f_add(r_u1[c_last], r_v1[c_last]));
      w_f1 = f_gs_scale(w_m1);
    end else begin
      w_e0 = f_add(r_u0[c_last], w_m0);
      w_f0 = f_sub(r_u0[c_last], w_m0);
      w_e1 = f_add(r_u1[c_last], w_m1);
      w_f1 = f_sub(r_u1[c_last], w_m1);
    end
    // Return butterfly results to the lanes they were taken from.
    w_y0 = w_e0;
    w_y1 = w_f0;
    w_y2 = w_e1;
    w_y3 = w_f1;
    if (r_str[c_last]) begin
      w_y1 = w_e1;
      w_y2 = w_f0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MUL_LAT; k++) begin
        r_vld[k] <= 1'b0;
        r_inv[k] <= 1'b0;
        r_str[k] <= 1'b0;
        r_byp[k] <= 1'b0;
        r_u0[k]  <= '0;
        r_v0[k]  <= '0;
        r_u1[k]  <= '0;
        r_v1[k]  <= '0;
      end
      r_out_valid <= 1'b0;
      r_o0 <= '0;
      r_o1 <= '0;
      r_o2 <= '0;
      r_o3 <= '0;
    end else if (i_en) begin
      for (int k = MUL_LAT-1; k > 0; k--) begin
        r_vld[k] <= r_vld[k-1];
        r_inv[k] <= r_inv[k-1];
        r_str[k] <= r_str[k-1];
        r_byp[k] <= r_byp[k-1];
        r_u0[k]  <= r_u0[k-1];
        r_v0[k]  <= r_v0[k-1];
        r_u1[k]  <= r_u1[k-1];
        r_v1[k]  <= r_v1[k-1];
      end
      r_vld[0] <= i_valid;
      r_inv[0] <= i_inv;
      r_str[0] <= i_strided;
      r_byp[0] <= i_bypass;
      r_u0[0]  <= w_u0;
      r_v0[0]  <= w_v0;
      r_u1[0]  <= w_u1;
      r_v1[0]  <= w_v1;
      r_out_valid <= r_vld[c_last];
      r_o0 <= w_y0;
      r_o1 <= w_y1;
      r_o2 <= w_y2;
      r_o3 <= w_y3;
    end
  end

  assign o_valid = r_out_valid;
  assign o_l0    = r_o0;
  assign o_l1    = r_o1;
  assign o_l2    = r_o2;
  assign o_l3    = r_o3;
endmodule

// ----------------------------------------------------------------------------
// Top: stage 1 and stage 2 plus a sideband delay line carrying the beat's
// mode bits and twiddles to stage 2.
// ----------------------------------------------------------------------------
module compact_bf_pipe #(
  parameter int DW      = 12,
  parameter int Q       = 3329,
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          fused,
  input  logic          inv,
  input  logic [DW-1:0] x0,
  input  logic [DW-1:0] x1,
  input  logic [DW-1:0] x2,
  input  logic [DW-1:0] x3,
  input  logic [DW-1:0] w1,
  input  logic [DW-1:0] w2,
  input  logic [DW-1:0] w3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y0,
  output logic [DW-1:0] y1,
  output logic [DW-1:0] y2,
  output logic [DW-1:0] y3
);
  localparam int c_stage_lat = MUL_LAT + 1;
  localparam int c_sb_last   = c_stage_lat - 1;

  logic          w_en;
  logic          w_s1_str;
  logic [DW-1:0] w_s1_wa, w_s1_wb;
  logic          w_s1_valid;
  logic [DW-1:0] w_a0, w_a1, w_a2, w_a3;
  logic          w_s2_fused, w_s2_inv, w_s2_str, w_s2_byp;
  logic [DW-1:0] w_s2_wa, w_s2_wb;

  logic          r_sb_fused [c_stage_lat];
  logic          r_sb_inv   [c_stage_lat];
  logic [DW-1:0] r_sb_w1    [c_stage_lat];
  logic [DW-1:0] r_sb_w2    [c_stage_lat];
  logic [DW-1:0] r_sb_w3    [c_stage_lat];

  // Whole pipe advances unless a valid output is being held.
  assign w_en     = ~out_valid | out_ready;
  assign in_ready = w_en;

  // Stage 1: DUAL pairs (0,1)/(2,3) with w1/w2; FUSED NTT pairs (0,2)/(1,3)
  // with w1 on both; FUSED INTT pairs (0,1)/(2,3) with w2/w3.
  assign w_s1_str = fused & ~inv;
  assign w_s1_wa  = (fused & inv) ? w2 : w1;
  assign w_s1_wb  = fused ? (inv ? w3 : w1) : w2;

  compact_bf_stage #(.DW(DW), .Q(Q), .MUL_LAT(MUL_LAT)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_en),
    .i_valid   (in_valid),
    .i_inv     (inv),
    .i_strided (w_s1_str),
    .i_bypass  (1'b0),
    .i_l0      (x0),
    .i_l1      (x1),
    .i_l2      (x2),
    .i_l3      (x3),
    .i_wa      (w_s1_wa),
    .i_wb      (w_s1_wb),
    .o_valid   (w_s1_valid),
    .o_l0      (w_a0),
    .o_l1      (w_a1),
    .o_l2      (w_a2),
    .o_l3      (w_a3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < c_stage_lat; k++) begin
        r_sb_fused[k] <= 1'b0;
        r_sb_inv[k]   <= 1'b0;
        r_sb_w1[k]    <= '0;
        r_sb_w2[k]    <= '0;
        r_sb_w3[k]    <= '0;
      end
    end else if (w_en) begin
      for (int k = c_stage_lat-1; k > 0; k--) begin
        r_sb_fused[k] <= r_sb_fused[k-1];
        r_sb_inv[k]   <= r_sb_inv[k-1];
        r_sb_w1[k]    <= r_sb_w1[k-1];
        r_sb_w2[k]    <= r_sb_w2[k-1];
        r_sb_w3[k]    <= r_sb_w3[k-1];
      end
      r_sb_fused[0] <= fused;
      r_sb_inv[0]   <= inv;
      r_sb_w1[0]    <= w1;
      r_sb_w2[0]    <= w2;
      r_sb_w3[0]    <= w3;
    end
  end

  // Stage 2: DUAL is a pure delay; FUSED NTT pairs (0,1)/(2,3) with w2/w3;
  // FUSED INTT pairs (0,2)/(1,3) with w1 on both.
  assign w_s2_fused = r_sb_fused[c_sb_last];
  assign w_s2_inv   = r_sb_inv[c_sb_last];
  assign w_s2_str   = w_s2_fused & w_s2_inv;
  assign w_s2_byp   = ~w_s2_fused;
  assign w_s2_wa    = w_s2_inv ? r_sb_w1[c_sb_last] : r_sb_w2[c_sb_last];
  assign w_s2_wb    = w_s2_inv ? r_sb_w1[c_sb_last] : r_sb_w3[c_sb_last];

  compact_bf_stage #(.DW(DW), .Q(Q), .MUL_LAT(MUL_LAT)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_en),
    .i_valid   (w_s1_valid),
    .i_inv     (w_s2_inv),
    .i_strided (w_s2_str),
    .i_bypass  (w_s2_byp),
    .i_l0      (w_a0),
    .i_l1      (w_a1),
    .i_l2      (w_a2),
    .i_l3      (w_a3),
    .i_wa      (w_s2_wa),
    .i_wb      (w_s2_wb),
    .o_valid   (out_valid),
    .o_l0      (y0),
    .o_l1      (y1),
    .o_l2      (y2),
    .o_l3      (y3)
  );
endmodule
`default_nettype wire
